// File: rtl/musicbox_pkg.sv
// Shared types and constants for the music box song path (ROM entry layout, sequencer states).
// ARTIC_GAP_EN adds the GAP state to the sequencer state enum.
package musicbox_pkg;
   localparam int DUR_W        = 6;
   localparam int NOTE_W       = 10;
   localparam int ENTRY_W      = DUR_W + NOTE_W;
   localparam int DUR_MSB      = ENTRY_W - 1;
   localparam int DUR_LSB      = NOTE_W;
   localparam int NOTE_MSB     = NOTE_W - 1;
   localparam int NOTE_LSB     = 0;
   localparam logic [DUR_W-1:0] END_DUR = '0;
   localparam int DEF_TICK_DIV = 6_250_000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_LOAD,
      ST_PLAY
`ifdef ARTIC_GAP_EN
      , ST_GAP
`endif
   } seq_state_t;

   function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] entry);
      return entry[DUR_MSB:DUR_LSB];
   endfunction

   function automatic logic [NOTE_W-1:0] entry_note(input logic [ENTRY_W-1:0] entry);
      return entry[NOTE_MSB:NOTE_LSB];
   endfunction
endpackage

// File: rtl/beat_prescaler.sv
// Beat prescaler: counts 0..TICK_DIV-1 while enabled; the wrap back to 0 is the beat tick.
module beat_prescaler
   import musicbox_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic RESET,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] count_q;

   assign tick_o = en_i && (count_q == CW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (!RESET || clr_i) begin
         count_q <= '0;
      end else if (en_i) begin
         count_q <= tick_o ? '0 : count_q + CW'(1);
      end
   end
endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks the song ROM and holds each note for dur beat ticks ahead of the tone generator.
// Define ARTIC_GAP_EN to insert a one-tick silent GAP after every note.
module song_sequencer
   import musicbox_pkg::*;
#(
   parameter int TICK_DIV   = DEF_TICK_DIV,
   parameter int ADDR_W     = 9,
   parameter int SONG1_BASE = 256
) (
   input  logic               clk,
   input  logic               RESET,
   input  logic               play,
   input  logic               song_sel,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [ENTRY_W-1:0] rom_data,
   output logic [NOTE_W-1:0]  fullnote,
   output logic               note_valid,
   output logic               note_start,
   output logic               song_done
);
   seq_state_t         state_q;
   logic [ADDR_W-1:0]  rom_addr_q;
   logic [ENTRY_W-1:0] entry_q;
   logic [NOTE_W-1:0]  note_q;
   logic [NOTE_W-1:0]  fullnote_q;
   logic [DUR_W-1:0]   dur_cnt_q;
   logic               note_valid_q;
   logic               note_start_q;
   logic               song_done_q;
   logic               sel_q;

   logic [ADDR_W-1:0]  base_d;
   logic               sel_edge_d;
   logic               beat_phase;
   logic               presc_en;
   logic               presc_clr;
   logic               tick;

   assign base_d     = song_sel ? ADDR_W'(SONG1_BASE) : '0;
   assign sel_edge_d = (song_sel != sel_q) && (state_q != ST_IDLE);
   assign presc_clr  = (state_q == ST_LOAD);
`ifdef ARTIC_GAP_EN
   assign beat_phase = (state_q == ST_PLAY) || (state_q == ST_GAP);
`else
   assign beat_phase = (state_q == ST_PLAY);
`endif
   assign presc_en   = play && beat_phase;

   beat_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk    (clk),
      .RESET  (RESET),
      .clr_i  (presc_clr),
      .en_i   (presc_en),
      .tick_o (tick)
   );

   always_ff @(posedge clk) begin
      if (!RESET) begin
         state_q      <= ST_IDLE;
         rom_addr_q   <= '0;
         entry_q      <= '0;
         note_q       <= '0;
         fullnote_q   <= '0;
         dur_cnt_q    <= '0;
         note_valid_q <= 1'b0;
         note_start_q <= 1'b0;
         song_done_q  <= 1'b0;
         sel_q        <= song_sel;
      end else begin
         sel_q        <= song_sel;
         note_start_q <= 1'b0;
         song_done_q  <= 1'b0;
         // A song change outranks everything, including an end marker sitting in LOAD.
         if (sel_edge_d) begin
            fullnote_q   <= '0;
            note_valid_q <= 1'b0;
            rom_addr_q   <= base_d;
            state_q      <= ST_FETCH;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  rom_addr_q <= base_d;
                  if (play) state_q <= ST_FETCH;
               end
               ST_FETCH: state_q <= ST_WAIT;
               ST_WAIT: begin
                  entry_q <= rom_data;
                  state_q <= ST_LOAD;
               end
               ST_LOAD: begin
                  if (entry_dur(entry_q) == END_DUR) begin
                     song_done_q  <= 1'b1;
                     rom_addr_q   <= base_d;
                     fullnote_q   <= '0;
                     note_valid_q <= 1'b0;
                     state_q      <= ST_FETCH;
                  end else begin
                     note_q       <= entry_note(entry_q);
                     fullnote_q   <= entry_note(entry_q);
                     dur_cnt_q    <= entry_dur(entry_q);
                     note_start_q <= 1'b1;
                     note_valid_q <= 1'b1;
                     state_q      <= ST_PLAY;
                  end
               end
               ST_PLAY: begin
                  // Paused notes go silent but keep note_q so resume is seamless.
                  fullnote_q <= play ? note_q : '0;
                  if (tick) begin
                     dur_cnt_q <= dur_cnt_q - DUR_W'(1);
                     if (dur_cnt_q == DUR_W'(1)) begin
                        rom_addr_q <= rom_addr_q + ADDR_W'(1);
`ifdef ARTIC_GAP_EN
                        fullnote_q <= '0;
                        state_q    <= ST_GAP;
`else
                        state_q    <= ST_FETCH;
`endif
                     end
                  end
               end
`ifdef ARTIC_GAP_EN
               ST_GAP: begin
                  if (tick) state_q <= ST_FETCH;
               end
`endif
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign rom_addr   = rom_addr_q;
   assign fullnote   = fullnote_q;
   assign note_valid = note_valid_q;
   assign note_start = note_start_q;
   assign song_done  = song_done_q;
endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with TICK_DIV=4 and a 1-cycle-latency song ROM model.
// Honours ARTIC_GAP_EN: expected spacings grow by one tick and the gap scenario is added.
module tb_song_sequencer;
   localparam int TD = 4;
`ifdef ARTIC_GAP_EN
   localparam int GAP_CYC = TD;
`else
   localparam int GAP_CYC = 0;
`endif

   logic        clk = 1'b0;
   logic        RESET = 1'b0;
   logic        play = 1'b0;
   logic        song_sel = 1'b0;
   logic [8:0]  rom_addr;
   logic [15:0] rom_data;
   logic [9:0]  fullnote;
   logic        note_valid;
   logic        note_start;
   logic        song_done;

   logic [15:0] rom [0:511];
   int tests = 0;
   int fails = 0;
   int done_cnt = 0;

   song_sequencer #(.TICK_DIV(TD), .ADDR_W(9), .SONG1_BASE(256)) dut (
      .clk        (clk),
      .RESET      (RESET),
      .play       (play),
      .song_sel   (song_sel),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .fullnote   (fullnote),
      .note_valid (note_valid),
      .note_start (note_start),
      .song_done  (song_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   always @(posedge clk) begin
      #1;
      if (song_done) done_cnt++;
   end

   function automatic logic [15:0] ent(input int d, input int n);
      return {d[5:0], n[9:0]};
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < 512; i++) rom[i] = 16'h0000;
      rom[256] = ent(1, 'h1A1);
      rom[257] = ent(0, 0);
   endtask

   task automatic do_reset();
      RESET = 1'b0;
      repeat (3) @(negedge clk);
      RESET = 1'b1;
   endtask

   task automatic wait_start(input int max_cyc, output int cyc, output bit found);
      found = 1'b0;
      cyc = 0;
      while (!found && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
         if (note_start) found = 1'b1;
      end
   endtask

   task automatic test_reset();
      clear_rom();
      rom[0] = ent(2, 'h025);
      rom[1] = ent(1, 'h000);
      rom[2] = ent(0, 'h3FF);
      play = 1'b1;
      song_sel = 1'b0;
      RESET = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if ({rom_addr, fullnote, note_valid, note_start, song_done} !== 23'd0) begin
         fails++;
         $display("FAIL reset_outputs: got addr=%h note=%h valid=%b start=%b done=%b, expected all zero",
                  rom_addr, fullnote, note_valid, note_start, song_done);
      end
      RESET = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         tests++;
         if (note_start !== 1'(k == 4)) begin
            fails++;
            $display("FAIL first_start_cycle%0d: got note_start=%b expected %b", k, note_start, k == 4);
         end
      end
      tests++;
      if (fullnote !== 10'h025) begin
         fails++;
         $display("FAIL first_note: got %h expected 025", fullnote);
      end
      tests++;
      if (note_valid !== 1'b1) begin
         fails++;
         $display("FAIL first_valid: got %b expected 1", note_valid);
      end
   endtask

   task automatic test_sequence();
      int bad;
      int cyc;
      bit found;
      logic [9:0] exp;
      bad = 0;
      for (int i = 1; i <= 10 + GAP_CYC; i++) begin
         @(negedge clk);
         exp = (GAP_CYC > 0 && i >= 8) ? 10'h000 : 10'h025;
         if (fullnote !== exp || note_start !== 1'b0) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL note_hold: got %0d bad cycles expected 0", bad);
      end
      @(negedge clk);
      tests++;
      if (note_start !== 1'b1 || fullnote !== 10'h000) begin
         fails++;
         $display("FAIL rest_start: got start=%b note=%h expected start=1 note=000", note_start, fullnote);
      end
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!song_done && cyc < 30);
      tests++;
      if (cyc != 7 + GAP_CYC) begin
         fails++;
         $display("FAIL song_done_timing: got %0d cycles expected %0d", cyc, 7 + GAP_CYC);
      end
      tests++;
      if (rom_addr !== 9'd0 || note_valid !== 1'b0 || fullnote !== 10'h000) begin
         fails++;
         $display("FAIL end_marker_state: got addr=%h valid=%b note=%h expected addr=000 valid=0 note=000",
                  rom_addr, note_valid, fullnote);
      end
      wait_start(10, cyc, found);
      tests++;
      if (!found || cyc != 3 || fullnote !== 10'h025) begin
         fails++;
         $display("FAIL loop_restart: got found=%b cyc=%0d note=%h expected found=1 cyc=3 note=025",
                  found, cyc, fullnote);
      end
   endtask

   task automatic test_pause();
      int bad;
      int cyc;
      bit found;
      clear_rom();
      rom[0] = ent(3, 'h155);
      rom[1] = ent(2, 'h0AA);
      rom[2] = ent(0, 0);
      play = 1'b1;
      do_reset();
      wait_start(10, cyc, found);
      tests++;
      if (!found || fullnote !== 10'h155) begin
         fails++;
         $display("FAIL pause_first_note: got found=%b note=%h expected found=1 note=155", found, fullnote);
      end
      repeat (3) @(negedge clk);
      play = 1'b0;
      bad = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (fullnote !== 10'h000 || note_valid !== 1'b1 || note_start !== 1'b0) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL pause_silence: got %0d bad cycles expected 0", bad);
      end
      play = 1'b1;
      @(negedge clk);
      tests++;
      if (fullnote !== 10'h155) begin
         fails++;
         $display("FAIL pause_resume_note: got %h expected 155", fullnote);
      end
      wait_start(40, cyc, found);
      tests++;
      if (!found || cyc != 11 + GAP_CYC) begin
         fails++;
         $display("FAIL pause_remaining: got found=%b cyc=%0d expected found=1 cyc=%0d", found, cyc, 11 + GAP_CYC);
      end
      tests++;
      if (fullnote !== 10'h0AA) begin
         fails++;
         $display("FAIL pause_next_note: got %h expected 0AA", fullnote);
      end
   endtask

   task automatic test_song_change();
      int d0;
      int cyc;
      bit found;
      repeat (2) @(negedge clk);
      d0 = done_cnt;
      song_sel = 1'b1;
      @(negedge clk);
      tests++;
      if (fullnote !== 10'h000 || note_valid !== 1'b0 || rom_addr !== 9'd256) begin
         fails++;
         $display("FAIL sel_abort: got note=%h valid=%b addr=%h expected note=000 valid=0 addr=100",
                  fullnote, note_valid, rom_addr);
      end
      wait_start(10, cyc, found);
      tests++;
      if (!found || cyc != 3 || fullnote !== 10'h1A1) begin
         fails++;
         $display("FAIL sel_new_song: got found=%b cyc=%0d note=%h expected found=1 cyc=3 note=1A1",
                  found, cyc, fullnote);
      end
      tests++;
      if (done_cnt != d0) begin
         fails++;
         $display("FAIL sel_no_done: got %0d song_done pulses expected 0", done_cnt - d0);
      end
   endtask

   task automatic test_end_collision();
      int d0;
      int cyc;
      bit found;
      d0 = done_cnt;
      repeat (6 + GAP_CYC) @(negedge clk);
      song_sel = 1'b0;
      @(negedge clk);
      tests++;
      if (song_done !== 1'b0 || rom_addr !== 9'd0) begin
         fails++;
         $display("FAIL collision_state: got done=%b addr=%h expected done=0 addr=000", song_done, rom_addr);
      end
      wait_start(10, cyc, found);
      tests++;
      if (!found || cyc != 3 || fullnote !== 10'h155) begin
         fails++;
         $display("FAIL collision_refetch: got found=%b cyc=%0d note=%h expected found=1 cyc=3 note=155",
                  found, cyc, fullnote);
      end
      tests++;
      if (done_cnt != d0) begin
         fails++;
         $display("FAIL collision_no_done: got %0d song_done pulses expected 0", done_cnt - d0);
      end
   endtask

`ifdef ARTIC_GAP_EN
   task automatic test_gap();
      int bad;
      int cyc;
      bit found;
      logic [9:0] exp;
      clear_rom();
      rom[0] = ent(1, 'h011);
      rom[1] = ent(1, 'h022);
      rom[2] = ent(0, 0);
      song_sel = 1'b0;
      play = 1'b1;
      do_reset();
      wait_start(10, cyc, found);
      bad = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         exp = (i < 4) ? 10'h011 : 10'h000;
         if (fullnote !== exp || note_start !== 1'b0) bad++;
         if (i >= 4 && i <= 7 && note_valid !== 1'b1) bad++;
      end
      tests++;
      if (!found || bad != 0) begin
         fails++;
         $display("FAIL gap_shape: got found=%b bad=%0d expected found=1 bad=0", found, bad);
      end
      @(negedge clk);
      tests++;
      if (note_start !== 1'b1 || fullnote !== 10'h022) begin
         fails++;
         $display("FAIL gap_second_note: got start=%b note=%h expected start=1 note=022", note_start, fullnote);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_sequence();
      test_pause();
      test_song_change();
      test_end_collision();
`ifdef ARTIC_GAP_EN
      test_gap();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
